// File: rtl/otp_digit_gen_if.sv
// Request/result bundle between the OTP authentication FSM (master) and the
// digit generator (slave).
interface otp_digit_gen_if;
  logic        gen_req;
  logic [15:0] lfsr_digit;
  logic        lfsr_latch;
  logic        busy;

  modport master (output gen_req, input lfsr_digit, lfsr_latch, busy);
  modport slave  (input gen_req, output lfsr_digit, lfsr_latch, busy);
endinterface

// File: rtl/otp_digit_gen.sv
// 4-digit BCD OTP generator: free-running 16-bit LFSR sampled nibble-wise.
// Optional macro OTP_GEN_MOD10_EN: fold nibbles >9 by -10 instead of rejecting.
module otp_digit_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  otp_digit_gen_if.slave  bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [11:0] asm_q, asm_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] digit_q, digit_d;
  logic        latch_q, latch_d;
  logic [3:0]  nib, dig;
  logic        accept;

  // LFSR runs regardless of state so request timing perturbs the output.
  always_comb begin
    if (lfsr_q == 16'h0000) lfsr_d = SEED;
    else lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign nib = lfsr_q[3:0];

`ifdef OTP_GEN_MOD10_EN
  assign accept = 1'b1;
  assign dig    = (nib > 4'd9) ? nib - 4'd10 : nib;
`else
  assign accept = (nib <= 4'd9);
  assign dig    = nib;
`endif

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    latch_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.gen_req) begin
          state_d = COLLECT;
          asm_d   = '0;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (accept) begin
          asm_d = {asm_q[7:0], dig};
          cnt_d = cnt_q + 2'd1;
          // Fourth digit goes straight to the output, bypassing asm.
          if (cnt_q == 2'd3) begin
            digit_d = {asm_q, dig};
            latch_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      asm_q   <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      latch_q <= latch_d;
    end
  end

  assign bus.lfsr_digit = digit_q;
  assign bus.lfsr_latch = latch_q;
  assign bus.busy       = (state_q == COLLECT);

endmodule
